// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: reset/NOP constants, fetch FSM states and the IF/ID record.
package pipeline_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold beats flush, flush beats load; a flush keeps pc_plus4.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_INSTR
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   flush,
   input  logic   hold,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t q_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg.instr    <= NOP_WORD;
         q_reg.pc_plus4 <= 32'h0;
         q_reg.valid    <= 1'b0;
      end else if (hold) begin
         q_reg <= q_reg;
      end else if (flush) begin
         q_reg.instr <= NOP_WORD;
         q_reg.valid <= 1'b0;
      end else if (load) begin
         q_reg <= d;
      end else begin
         // neither loaded nor flushed: still a bubble, nothing real was fetched
         q_reg.instr <= NOP_WORD;
         q_reg.valid <= 1'b0;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, pending-redirect FSM, bubble counter and the IF/ID register.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_D,
   input  logic        branch_D,
   input  logic [31:0] branch_target_D,
   input  logic        jump_D,
   input  logic [31:0] jump_target_D,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_D,
   output logic [31:0] pc_plus4_D,
   output logic        valid_D,
   output logic [15:0] bubble_cnt
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  pend_pc_reg, pend_pc_next;
   logic [15:0]  bubble_cnt_reg, bubble_cnt_next;
   logic         load, flush, hold, cnt_freeze;
   logic         redirect, valid_next;
   logic [31:0]  target, pc_plus4;
   if_id_t       if_id_d, if_id_q;

   assign redirect = (jump_D | branch_D) & ~stall_D;
   assign target   = jump_D ? jump_target_D : branch_target_D;
   assign pc_plus4 = pc_reg + 32'd4;

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      pend_pc_next = pend_pc_reg;
      load         = 1'b0;
      flush        = 1'b0;
      hold         = 1'b0;
      cnt_freeze   = 1'b0;
      case (state_reg)
         FETCH: begin
            if (redirect) begin
               flush = 1'b1;
               if (imem_rdy) begin
                  pc_next = target;
               end else begin
                  pend_pc_next = target;
                  state_next   = DROP;
               end
            end else if (stall_D) begin
               hold       = 1'b1;
               cnt_freeze = 1'b1;
            end else if (imem_rdy) begin
               load    = 1'b1;
               pc_next = pc_plus4;
            end else begin
               flush = 1'b1;
            end
         end
         DROP: begin
            // the wrong-path fetch is still in flight; let it complete, then redirect
            hold  = stall_D;
            flush = ~stall_D;
            if (imem_rdy) begin
               pc_next    = pend_pc_reg;
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   assign valid_next = hold ? if_id_q.valid : load;

   always_comb begin
      bubble_cnt_next = bubble_cnt_reg;
      if (!cnt_freeze && !valid_next && bubble_cnt_reg != 16'hFFFF)
         bubble_cnt_next = bubble_cnt_reg + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= FETCH;
         pc_reg         <= RESET_PC;
         pend_pc_reg    <= 32'h0;
         bubble_cnt_reg <= 16'h0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         pend_pc_reg    <= pend_pc_next;
         bubble_cnt_reg <= bubble_cnt_next;
      end
   end

   assign if_id_d.instr    = imem_rdata;
   assign if_id_d.pc_plus4 = pc_plus4;
   assign if_id_d.valid    = 1'b1;

   if_id_reg #(.NOP_WORD(NOP_INSTR)) u_if_id (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .flush (flush),
      .hold  (hold),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign imem_req   = ~rst;
   assign imem_addr  = pc_reg;
   assign instr_D    = if_id_q.instr;
   assign pc_plus4_D = if_id_q.pc_plus4;
   assign valid_D    = if_id_q.valid;
   assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, meaning: instruction word placed in IF/ID on a bubble.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall_D  input  1  decode-stage hazard stall, the OR of the load-use and branch-operand hazard stalls; 1 = hold PC and IF/ID.
REQ-006 branch_D  input  1  branch taken, resolved in decode.
REQ-007 branch_target_D  input  32  branch destination.
REQ-008 jump_D  input  1  jump in decode.
REQ-009 jump_target_D  input  32  jump destination.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 imem_addr  output  32  fetch address, word aligned.
REQ-012 imem_rdy  input  1  memory accepts the request and returns data in the same cycle.
REQ-013 imem_rdata  input  32  instruction word, valid when imem_rdy=1.
REQ-014 instr_D  output  32  IF/ID instruction.
REQ-015 pc_plus4_D  output  32  IF/ID PC+4 of instr_D.
REQ-016 valid_D  output  1  IF/ID holds a real instruction, not a bubble.
REQ-017 bubble_cnt  output  16  count of cycles ending with valid_D=0 after the edge; saturates at 16'hFFFF.

Function
REQ-018 States: FETCH and DROP. imem_req=1 in both, except while rst=1 (imem_req=0). imem_addr=pc in both.
REQ-019 redirect = (jump_D | branch_D) & ~stall_D. target = jump_target_D if jump_D, else branch_target_D; jump wins if both are set.
REQ-020 FETCH, priority 1, redirect with imem_rdy=1: pc<=target; IF/ID<=bubble; discard imem_rdata; stay in FETCH.
REQ-021 FETCH, redirect with imem_rdy=0: pend_pc<=target; IF/ID<=bubble; pc and imem_addr unchanged; go to DROP.
REQ-022 FETCH, priority 2, stall_D=1: pc, IF/ID and bubble_cnt hold; any imem_rdata is discarded and refetched later.
REQ-023 FETCH, priority 3, imem_rdy=1: IF/ID<={imem_rdata, pc+4, valid=1}; pc<=pc+4.
REQ-024 FETCH, priority 4, imem_rdy=0: IF/ID<=bubble; pc holds.
REQ-025 DROP: imem_addr stays stable at the old pc until imem_rdy=1; branch_D and jump_D are ignored. IF/ID<=bubble unless stall_D=1, in which case IF/ID holds.
REQ-026 DROP, on imem_rdy=1: discard data; pc<=pend_pc; go to FETCH.
REQ-027 Bubble = {NOP_INSTR, pc_plus4_D unchanged, valid=0}. There is no branch delay slot; the wrong-path instruction is always squashed.
REQ-028 PC arithmetic is modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Targets are used as given; bits [1:0] are not checked.
REQ-029 No combinational path from stall_D, branch_D or jump_D to imem_addr or imem_req.

Reset
REQ-030 While rst=1 at an edge: pc<=RESET_PC, state<=FETCH, pend_pc<=0, instr_D<=NOP_INSTR, pc_plus4_D<=0, valid_D<=0, bubble_cnt<=0.
REQ-031 rst overrides all other inputs, including mid-DROP; the outstanding fetch is abandoned.
REQ-032 The first fetch of RESET_PC is issued in the cycle after rst deasserts.

Structure
REQ-033 The shared package pipeline_pkg holds RESET_PC_DEFAULT, NOP_INSTR, the state enumeration {FETCH, DROP} and the IF/ID record layout.
REQ-034 The IF/ID register is the sub-module if_id_reg, with inputs load, flush and hold; fetch_stage holds the PC, pend_pc, FSM and counter.

Verification
REQ-035 Reset, then imem_rdy=1 constantly with rdata=addr: instr_D reads 0, 4, 8 on successive cycles, with valid_D=1 from the 2nd post-reset cycle.
REQ-036 stall_D=1 for 2 cycles at pc=8: instr_D stays 4 and imem_addr stays 8; after release instr_D=8 next cycle.
REQ-037 branch_D=1 with target 32'h40 and imem_rdy=1: the next cycle shows valid_D=0, instr_D=0, imem_addr=32'h40; then instr_D=32'h40.
REQ-038 jump_D=1 (target 32'h80) with imem_rdy=0 for 3 cycles: imem_addr holds the old pc and valid_D=0 throughout; after rdy the next imem_addr=32'h80.
REQ-039 jump_D and branch_D both set, targets 32'h100 and 32'h200: fetch goes to 32'h100. Also rst asserted in DROP: next imem_addr=RESET_PC and pend_pc is dropped.
REQ-040 imem_rdy=0 held for 70000 cycles: bubble_cnt saturates at 16'hFFFF; pc=0xFFFFFFFC with rdy=1 wraps imem_addr to 0.
